// File: rtl/bus_transfer_arbiter_if.sv
// rtl/bus_transfer_arbiter_if.sv - request/register-bus bundle between control logic, arbiter and register file
interface bus_transfer_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REG    = 8
);
  localparam int IDX_W = $clog2(NUM_REG);
  localparam int ID_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*IDX_W-1:0]      i_req_src;
  logic [NUM_REQ*IDX_W-1:0]      i_req_dst;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REG*DATA_WIDTH-1:0] i_reg_bus;
  logic [DATA_WIDTH-1:0]         o_bus;
  logic [NUM_REG-1:0]            o_oe;
  logic [NUM_REG-1:0]            o_we;
  logic                          o_busy;
  logic                          o_done;
  logic [ID_W-1:0]               o_done_id;
  logic                          o_err;

  // Arbiter side: consumes requests and register outputs, drives enables and the bus
  modport master (
    input  i_req_valid, i_req_src, i_req_dst, i_reg_bus,
    output o_req_ready, o_bus, o_oe, o_we, o_busy, o_done, o_done_id, o_err
  );

  // Requester / register-file side
  modport slave (
    output i_req_valid, i_req_src, i_req_dst, i_reg_bus,
    input  o_req_ready, o_bus, o_oe, o_we, o_busy, o_done, o_done_id, o_err
  );
endinterface

// File: rtl/bus_transfer_arbiter.sv
// rtl/bus_transfer_arbiter.sv - round-robin register-to-register move sequencer; BUS_ARB_FAST_XFER_EN drops the DRIVE state
module bus_transfer_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REG    = 8
) (
  input logic                    i_clk,
  input logic                    i_rst,
  bus_transfer_arbiter_if.master bus_if
);

  localparam int IDX_W = $clog2(NUM_REG);
  localparam int ID_W  = $clog2(NUM_REQ);
  // One extra bit so indices that do not fit the register count can be detected
  localparam logic [IDX_W:0] REG_LIMIT = (IDX_W+1)'(NUM_REG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd2
`ifndef BUS_ARB_FAST_XFER_EN
    ,S_DRIVE = 2'd1
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]  src_q, dst_q;
  logic [ID_W-1:0]   id_q;
  logic              err_q;

  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  int                cand_int;
  logic [IDX_W-1:0]  src_sel, dst_sel;
  logic              bad_idx;
  logic              accept;

  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REG-1:0]    oe, we, oe_dec, we_dec;
  logic [DATA_WIDTH-1:0] bus_v, src_data;
  logic                  done;

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    cand_int = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_int = (int'(ptr_q) + i) % NUM_REQ;
      cand     = ID_W'(cand_int);
      if (!found && bus_if.i_req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Pick out the winner's src/dst fields and flag indices beyond the register count
  always_comb begin
    src_sel = '0;
    dst_sel = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win == ID_W'(r)) begin
        src_sel = bus_if.i_req_src[r*IDX_W +: IDX_W];
        dst_sel = bus_if.i_req_dst[r*IDX_W +: IDX_W];
      end
    end
    bad_idx = ({1'b0, src_sel} >= REG_LIMIT) || ({1'b0, dst_sel} >= REG_LIMIT);
    accept  = (state_q == S_IDLE) && found;
    ptr_d   = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end

  // Decode the latched indices into one-hot enables and the selected source data
  always_comb begin
    oe_dec   = '0;
    we_dec   = '0;
    src_data = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      if (src_q == IDX_W'(k)) begin
        oe_dec[k] = 1'b1;
        src_data  = bus_if.i_reg_bus[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (dst_q == IDX_W'(k)) begin
        we_dec[k] = 1'b1;
      end
    end
  end

  // FSM next state and per-state outputs
  always_comb begin
    state_d = state_q;
    ready   = '0;
    oe      = '0;
    we      = '0;
    bus_v   = '0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          // A reset in the same cycle must not look like a handshake
          ready[win] = ~i_rst;
          if (bad_idx) begin
            state_d = S_IDLE;
          end else begin
`ifdef BUS_ARB_FAST_XFER_EN
            state_d = S_WRITE;
`else
            state_d = S_DRIVE;
`endif
          end
        end
      end
`ifndef BUS_ARB_FAST_XFER_EN
      S_DRIVE: begin
        oe      = oe_dec;
        bus_v   = src_data;
        state_d = S_WRITE;
      end
`endif
      S_WRITE: begin
        oe      = oe_dec;
        bus_v   = src_data;
        we      = we_dec;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer and latched transfer registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && bad_idx;
      if (accept) begin
        src_q <= src_sel;
        dst_q <= dst_sel;
        id_q  <= win;
        ptr_q <= ptr_d;
      end
    end
  end

  assign bus_if.o_req_ready = ready;
  assign bus_if.o_oe        = oe;
  assign bus_if.o_we        = we;
  assign bus_if.o_bus       = bus_v;
  assign bus_if.o_done      = done;
  assign bus_if.o_err       = err_q;
  assign bus_if.o_busy      = (state_q != S_IDLE);
  assign bus_if.o_done_id   = (done || err_q) ? id_q : '0;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// tb/tb_bus_transfer_arbiter.sv - directed self-checking bench for bus_transfer_arbiter
module tb_bus_transfer_arbiter;

`ifdef BUS_ARB_FAST_XFER_EN
  localparam int XFER = 2;
`else
  localparam int XFER = 3;
`endif

  logic i_clk;
  logic i_rst;
  int   n_vec;
  int   n_miss;

  bus_transfer_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4), .NUM_REG(8)) bif ();
  bus_transfer_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4), .NUM_REG(6)) bif6 ();

  bus_transfer_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .NUM_REG(8)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus_if (bif)
  );

  bus_transfer_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .NUM_REG(6)) dut6 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus_if (bif6)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rr_dst [4] = '{4, 5, 6, 3};
  int rr_bus [4] = '{8'h00, 8'h11, 8'hA5, 8'h33};

  initial begin
    n_vec  = 0;
    n_miss = 0;
    i_rst  = 1'b1;
    bif.i_req_valid  = 4'hF;
    bif.i_req_src    = '0;
    bif.i_req_dst    = '0;
    bif.i_reg_bus    = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'hA5, 8'h11, 8'h00};
    bif6.i_req_valid = 4'h0;
    bif6.i_req_src   = '0;
    bif6.i_req_dst   = '0;
    bif6.i_reg_bus   = {8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h60};

    // reset held two edges with every request valid
    cyc();
    cyc();
    #1;
    chk("rst_ready", 32'(bif.o_req_ready), 32'h0);
    chk("rst_oe",    32'(bif.o_oe),        32'h0);
    chk("rst_we",    32'(bif.o_we),        32'h0);
    chk("rst_done",  32'(bif.o_done),      32'h0);
    chk("rst_busy",  32'(bif.o_busy),      32'h0);
    chk("rst_err",   32'(bif.o_err),       32'h0);
    chk("rst_busy6", 32'(bif6.o_busy),     32'h0);

    // single move req0: r2 -> r5
    i_rst = 1'b0;
    bif.i_req_valid = 4'b0001;
    bif.i_req_src   = {3'd0, 3'd0, 3'd0, 3'd2};
    bif.i_req_dst   = {3'd0, 3'd0, 3'd0, 3'd5};
    #1;
    chk("mv_ready", 32'(bif.o_req_ready), 32'h1);
    chk("mv_busy0", 32'(bif.o_busy),      32'h0);
    cyc();
    bif.i_req_valid = 4'b0000;
    bif.i_req_src   = {3'd0, 3'd0, 3'd0, 3'd7};
    #1;
`ifndef BUS_ARB_FAST_XFER_EN
    chk("mv_drv_oe",    32'(bif.o_oe),        32'h04);
    chk("mv_drv_bus",   32'(bif.o_bus),       32'hA5);
    chk("mv_drv_we",    32'(bif.o_we),        32'h00);
    chk("mv_drv_done",  32'(bif.o_done),      32'h0);
    chk("mv_drv_busy",  32'(bif.o_busy),      32'h1);
    chk("mv_drv_ready", 32'(bif.o_req_ready), 32'h0);
    cyc();
    #1;
`endif
    chk("mv_wr_oe",   32'(bif.o_oe),      32'h04);
    chk("mv_wr_bus",  32'(bif.o_bus),     32'hA5);
    chk("mv_wr_we",   32'(bif.o_we),      32'h20);
    chk("mv_wr_done", 32'(bif.o_done),    32'h1);
    chk("mv_wr_id",   32'(bif.o_done_id), 32'h0);
    cyc();
    #1;
    chk("mv_idle_busy", 32'(bif.o_busy), 32'h0);
    chk("mv_idle_we",   32'(bif.o_we),   32'h0);

    // round-robin with all requesters valid; req3 is a src==dst move
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    bif.i_req_valid = 4'hF;
    bif.i_req_src   = {3'd3, 3'd2, 3'd1, 3'd0};
    bif.i_req_dst   = {3'd3, 3'd6, 3'd5, 3'd4};
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #1;
      chk("rr_ready", 32'(bif.o_req_ready), 32'(1) << g);
      for (int j = 1; j < XFER; j++) cyc();
      #1;
      chk("rr_we",   32'(bif.o_we),      32'(1) << rr_dst[g]);
      chk("rr_oe",   32'(bif.o_oe),      32'(1) << g);
      chk("rr_bus",  32'(bif.o_bus),     32'(rr_bus[g]));
      chk("rr_id",   32'(bif.o_done_id), 32'(g));
      cyc();
    end

    // reset while a transfer is in flight; pointer must return to 0
    bif.i_req_valid = 4'b0001;
    bif.i_req_src   = {3'd3, 3'd2, 3'd1, 3'd1};
    bif.i_req_dst   = {3'd3, 3'd6, 3'd5, 3'd6};
    #1;
    chk("ab_ready", 32'(bif.o_req_ready), 32'h1);
    cyc();
    bif.i_req_valid = 4'b0000;
    i_rst = 1'b1;
    #1;
`ifndef BUS_ARB_FAST_XFER_EN
    chk("ab_drv_oe",   32'(bif.o_oe),   32'h02);
    chk("ab_drv_we",   32'(bif.o_we),   32'h00);
    chk("ab_drv_done", 32'(bif.o_done), 32'h0);
`endif
    cyc();
    #1;
    chk("ab_busy", 32'(bif.o_busy), 32'h0);
    chk("ab_we",   32'(bif.o_we),   32'h0);
    chk("ab_done", 32'(bif.o_done), 32'h0);
    chk("ab_oe",   32'(bif.o_oe),   32'h0);
    i_rst = 1'b0;
    bif.i_req_valid = 4'b1001;
    #1;
    chk("ab_ptr0", 32'(bif.o_req_ready), 32'h1);
    cyc();
    bif.i_req_valid = 4'b0000;
    for (int j = 2; j < XFER; j++) cyc();
    #1;
    chk("ab2_we",   32'(bif.o_we),      32'h40);
    chk("ab2_done", 32'(bif.o_done),    32'h1);
    chk("ab2_id",   32'(bif.o_done_id), 32'h0);
    cyc();
    #1;
    chk("ab2_busy", 32'(bif.o_busy), 32'h0);

    // out-of-range src on the 6-register instance
    bif6.i_req_valid = 4'b0010;
    bif6.i_req_src   = {3'd0, 3'd0, 3'd7, 3'd0};
    bif6.i_req_dst   = {3'd0, 3'd0, 3'd2, 3'd0};
    #1;
    chk("er_ready", 32'(bif6.o_req_ready), 32'h2);
    chk("er_err0",  32'(bif6.o_err),       32'h0);
    cyc();
    bif6.i_req_valid = 4'b0000;
    #1;
    chk("er_err",  32'(bif6.o_err),     32'h1);
    chk("er_id",   32'(bif6.o_done_id), 32'h1);
    chk("er_oe",   32'(bif6.o_oe),      32'h0);
    chk("er_we",   32'(bif6.o_we),      32'h0);
    chk("er_busy", 32'(bif6.o_busy),    32'h0);
    chk("er_done", 32'(bif6.o_done),    32'h0);
    cyc();
    #1;
    chk("er_err_clr", 32'(bif6.o_err),  32'h0);
    chk("er_busy2",   32'(bif6.o_busy), 32'h0);

    // out-of-range dst, requester 0 (pointer now at 2)
    bif6.i_req_valid = 4'b0001;
    bif6.i_req_src   = {3'd0, 3'd0, 3'd0, 3'd1};
    bif6.i_req_dst   = {3'd0, 3'd0, 3'd0, 3'd6};
    #1;
    chk("ed_ready", 32'(bif6.o_req_ready), 32'h1);
    cyc();
    bif6.i_req_valid = 4'b0000;
    #1;
    chk("ed_err", 32'(bif6.o_err),     32'h1);
    chk("ed_id",  32'(bif6.o_done_id), 32'h0);
    chk("ed_we",  32'(bif6.o_we),      32'h0);
    cyc();

    // highest legal index on the 6-register instance: r5 -> r0
    bif6.i_req_valid = 4'b0100;
    bif6.i_req_src   = {3'd0, 3'd5, 3'd0, 3'd0};
    bif6.i_req_dst   = {3'd0, 3'd0, 3'd0, 3'd0};
    #1;
    chk("bd_ready", 32'(bif6.o_req_ready), 32'h4);
    cyc();
    bif6.i_req_valid = 4'b0000;
    for (int j = 2; j < XFER; j++) cyc();
    #1;
    chk("bd_oe",  32'(bif6.o_oe),      32'h20);
    chk("bd_we",  32'(bif6.o_we),      32'h01);
    chk("bd_bus", 32'(bif6.o_bus),     32'h65);
    chk("bd_id",  32'(bif6.o_done_id), 32'h2);
    chk("bd_err", 32'(bif6.o_err),     32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
